user_gpio_evt: RTL and testbench

Parametrised successor to the plain GPIO plugin, built as a user plugin of the DIOB2 blackbox.
- Inputs: per-bit synchronisation, programmable debounce, and rise/fall edge capture into a sticky write-1-to-clear event register with a maskable interrupt.
- Outputs: static level, plus a per-bit one-shot pulse of programmable length.
- Accessed through a simple synchronous register port that the flex-bus slave adapter drives.

---
 rtl/user_gpio_evt_pkg.sv | 42 ++++
 rtl/user_gpio_evt_debounce.sv | 37 +++
 rtl/user_gpio_evt.sv | 119 +++++++++++
 tb/tb_user_gpio_evt.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_gpio_evt_pkg.sv
// user_gpio_evt_pkg: register bank indices and address decode helpers for user_gpio_evt.
package user_gpio_evt_pkg;

    typedef enum logic [3:0] {
        BANK_IN       = 4'd0,
        BANK_OUT      = 4'd1,
        BANK_RISE_EN  = 4'd2,
        BANK_FALL_EN  = 4'd3,
        BANK_EVT      = 4'd4,
        BANK_IRQ_MASK = 4'd5,
        BANK_PULSE    = 4'd6,
        CFG_DEB       = 4'd7,
        CFG_PLEN      = 4'd8,
        BANK_NONE     = 4'd15
    } bank_t;

    typedef struct packed {
        bank_t       bank;
        logic [15:0] word;
    } reg_sel_t;

    function automatic int nr_words(input int nr_ios, input int data_w);
        return (nr_ios + data_w - 1) / data_w;
    endfunction

    // Banks occupy nw consecutive words each; the two config words follow bank 6.
    function automatic reg_sel_t addr_decode(input int addr, input int nw);
        reg_sel_t s;
        s.bank = BANK_NONE;
        s.word = '0;
        if (addr < 7 * nw) begin
            s.bank = bank_t'(4'(addr / nw));
            s.word = 16'(addr % nw);
        end else if (addr == 7 * nw) begin
            s.bank = CFG_DEB;
        end else if (addr == 7 * nw + 1) begin
            s.bank = CFG_PLEN;
        end
        return s;
    endfunction

endpackage

// File: rtl/user_gpio_evt_debounce.sv
// gpio_debounce: 2-FF synchroniser, programmable debounce cell and edge detect for one pin.
module gpio_debounce #(
    parameter int DEB_W = 8
) (
    input  logic             clk_sys,
    input  logic             rstn_sys,
    input  logic             pin,
    input  logic [DEB_W-1:0] limit,
    output logic             stable,
    output logic             rise,
    output logic             fall
);
    logic             s1, s2, stable_d;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (!rstn_sys) begin
            {s1, s2, stable, stable_d, cnt} <= '0;
        end else begin
            s1       <= pin;
            s2       <= s1;
            stable_d <= stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == limit) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

endmodule

// File: rtl/user_gpio_evt.sv
// user_gpio_evt: GPIO with debounced inputs, sticky edge events + irq, and one-shot output pulses
// behind a simple synchronous register port.
module user_gpio_evt
    import user_gpio_evt_pkg::*;
#(
    parameter int NR_IOS  = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEB_W   = 8,
    parameter int PULSE_W = 16
) (
    input  logic              clk_sys,
    input  logic              rstn_sys,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              reg_ack,
    input  logic [NR_IOS-1:0] gpio_in,
    output logic [NR_IOS-1:0] gpio_out,
    output logic              irq
);
    localparam int NW = nr_words(NR_IOS, DATA_W);
    localparam int PW = NW * DATA_W;

    reg_sel_t           sel;
    int                 shift;
    logic [NR_IOS-1:0]  in_lvl, rise, fall, pulse;
    logic [NR_IOS-1:0]  out_r, rise_en, fall_en, evt, irq_mask;
    logic [NR_IOS-1:0]  wd, ws, evt_set, evt_clr, fire, rd_vec;
    logic [DEB_W-1:0]   deb_limit;
    logic [PULSE_W-1:0] pulse_len;
    logic [DATA_W-1:0]  rd_word;
    logic               wr_out, wr_rise, wr_fall, wr_mask, wr_evt, wr_pulse, wr_deb, wr_plen;

    assign sel   = addr_decode(int'(reg_addr), NW);
    assign shift = int'(sel.word) * DATA_W;

    // Write data and word-select mask placed at the addressed word; bits at or above NR_IOS drop off.
    assign wd = NR_IOS'(PW'(reg_wdata) << shift);
    assign ws = NR_IOS'(PW'({DATA_W{1'b1}}) << shift);

    assign wr_out   = reg_wr && sel.bank == BANK_OUT;
    assign wr_rise  = reg_wr && sel.bank == BANK_RISE_EN;
    assign wr_fall  = reg_wr && sel.bank == BANK_FALL_EN;
    assign wr_mask  = reg_wr && sel.bank == BANK_IRQ_MASK;
    assign wr_evt   = reg_wr && sel.bank == BANK_EVT;
    assign wr_pulse = reg_wr && sel.bank == BANK_PULSE;
    assign wr_deb   = reg_wr && sel.bank == CFG_DEB;
    assign wr_plen  = reg_wr && sel.bank == CFG_PLEN;

    assign evt_set = (rise & rise_en) | (fall & fall_en);
    assign evt_clr = wr_evt ? wd : '0;
    assign fire    = wr_pulse && pulse_len != '0 ? wd : '0;

    assign rd_vec = sel.bank == BANK_IN       ? in_lvl   :
                    sel.bank == BANK_OUT      ? out_r    :
                    sel.bank == BANK_RISE_EN  ? rise_en  :
                    sel.bank == BANK_FALL_EN  ? fall_en  :
                    sel.bank == BANK_EVT      ? evt      :
                    sel.bank == BANK_IRQ_MASK ? irq_mask : '0;

    assign rd_word = sel.bank == CFG_DEB  ? DATA_W'(deb_limit) :
                     sel.bank == CFG_PLEN ? DATA_W'(pulse_len) :
                     DATA_W'(PW'(rd_vec) >> shift);

    always_ff @(posedge clk_sys) begin
        if (!rstn_sys) begin
            out_r     <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            irq_mask  <= '0;
            evt       <= '0;
            deb_limit <= '0;
            pulse_len <= '0;
            irq       <= 1'b0;
            gpio_out  <= '0;
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            if (wr_out) out_r <= (out_r & ~ws) | wd;
            if (wr_rise) rise_en <= (rise_en & ~ws) | wd;
            if (wr_fall) fall_en <= (fall_en & ~ws) | wd;
            if (wr_mask) irq_mask <= (irq_mask & ~ws) | wd;
            if (wr_deb) deb_limit <= DEB_W'(reg_wdata);
            if (wr_plen) pulse_len <= PULSE_W'(reg_wdata);
            // Set is OR-ed in after the clear so a coincident edge survives the W1C.
            evt       <= (evt & ~evt_clr) | evt_set;
            irq       <= |(evt & irq_mask);
            gpio_out  <= out_r | pulse;
            reg_ack   <= reg_wr | reg_rd;
            reg_rdata <= reg_rd && !reg_wr ? rd_word : '0;
        end
    end

    for (genvar i = 0; i < NR_IOS; i++) begin : g_bit
        logic [PULSE_W-1:0] pcnt;

        gpio_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk_sys  (clk_sys),
            .rstn_sys (rstn_sys),
            .pin      (gpio_in[i]),
            .limit    (deb_limit),
            .stable   (in_lvl[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );

        always_ff @(posedge clk_sys) begin
            if (!rstn_sys) pcnt <= '0;
            else if (fire[i]) pcnt <= pulse_len;
            else if (pcnt != '0) pcnt <= pcnt - 1'b1;
        end

        assign pulse[i] = pcnt != '0;
    end

endmodule

// File: tb/tb_user_gpio_evt.sv
// tb_user_gpio_evt: vector table, timing sequences and randomized register/pin traffic for user_gpio_evt.
module tb_user_gpio_evt;
    localparam int NR_IOS  = 40;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int DEB_W   = 8;
    localparam int PULSE_W = 16;

    localparam logic [7:0] A_IN = 8'd0, A_OUT = 8'd2, A_RISE = 8'd4, A_FALL = 8'd6;
    localparam logic [7:0] A_EVT = 8'd8, A_MASK = 8'd10, A_PULSE = 8'd12, A_DEB = 8'd14, A_PLEN = 8'd15;

    logic              clk_sys = 1'b0;
    logic              rstn_sys = 1'b0;
    logic [ADDR_W-1:0] reg_addr = '0;
    logic              reg_wr = 1'b0;
    logic              reg_rd = 1'b0;
    logic [DATA_W-1:0] reg_wdata = '0;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_ack;
    logic [NR_IOS-1:0] gpio_in = '0;
    logic [NR_IOS-1:0] gpio_out;
    logic              irq;

    user_gpio_evt #(
        .NR_IOS(NR_IOS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEB_W(DEB_W), .PULSE_W(PULSE_W)
    ) dut (
        .clk_sys   (clk_sys),
        .rstn_sys  (rstn_sys),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    logic [39:0] out_m, rise_m, fall_m, mask_m, evt_m, pin_m, old_pin;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_sys);
        reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
        @(negedge clk_sys);
        reg_wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk_sys);
        reg_addr = a; reg_rd = 1'b1;
        @(negedge clk_sys);
        reg_rd = 1'b0;
        chk({name, "_ack"}, reg_ack, 1);
        chk(name, reg_rdata, exp);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rstn_sys = 1'b0; gpio_in = '0; reg_wr = 1'b0; reg_rd = 1'b0;
        repeat (2) @(negedge clk_sys);
        rstn_sys = 1'b1;
    endtask

    // Fire PULSE bit 1 at edge e; optionally retrigger at e+2. gpio_out[1] must be high after edges e+1..e+last.
    task automatic pulse_seq(input string name, input bit retrig, input int last);
        @(negedge clk_sys);
        reg_addr = A_PULSE; reg_wdata = 32'h2; reg_wr = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk_sys);
            reg_wr = retrig && j == 1;
            chk(name, gpio_out[1], j >= 1 && j <= last);
        end
        reg_wr = 1'b0;
    endtask

    function automatic logic [39:0] merge(input logic [39:0] v, input int w, input logic [31:0] d);
        return w == 1 ? {d[7:0], v[31:0]} : {v[39:32], d};
    endfunction

    function automatic logic [31:0] word_of(input logic [39:0] v, input int w);
        return w == 1 ? {24'h0, v[39:32]} : v[31:0];
    endfunction

    function automatic logic [39:0] bank_model(input int b);
        case (b)
            0: return pin_m;
            1: return out_m;
            2: return rise_m;
            3: return fall_m;
            4: return evt_m;
            default: return mask_m;
        endcase
    endfunction

    initial begin
        tbl[0]  = '{8'd2,   32'hA5A5_5A5A, 32'hA5A5_5A5A};
        tbl[1]  = '{8'd3,   32'hFFFF_FFFF, 32'h0000_00FF};
        tbl[2]  = '{8'd4,   32'h1234_5678, 32'h1234_5678};
        tbl[3]  = '{8'd7,   32'hDEAD_BEEF, 32'h0000_00EF};
        tbl[4]  = '{8'd10,  32'h0F0F_0000, 32'h0F0F_0000};
        tbl[5]  = '{8'd0,   32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{8'd12,  32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{8'd14,  32'h0000_01FF, 32'h0000_00FF};
        tbl[8]  = '{8'd15,  32'h0001_2345, 32'h0000_2345};
        tbl[9]  = '{8'd16,  32'hFFFF_FFFF, 32'h0};
        tbl[10] = '{8'd255, 32'h0000_0001, 32'h0};
        tbl[11] = '{8'd8,   32'hFFFF_FFFF, 32'h0};

        // Reset state
        do_reset();
        @(negedge clk_sys);
        chk("rst_gpio_out", gpio_out, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ack", reg_ack, 0);
        chk("rst_rdata", reg_rdata, 0);
        for (int a = 0; a <= 16; a++) rd_chk("rst_read", 8'(a), 32'h0);

        // Register map vectors
        foreach (tbl[n]) begin
            wr(tbl[n].addr, tbl[n].wdata);
            rd_chk("tbl_read", tbl[n].addr, tbl[n].exp);
        end
        chk("tbl_gpio_out", gpio_out, 40'hFF_A5A5_5A5A);
        chk("tbl_irq", irq, 0);

        // Simultaneous rd+wr: write performed, rdata 0
        @(negedge clk_sys);
        reg_addr = A_OUT; reg_wdata = 32'h55; reg_wr = 1'b1; reg_rd = 1'b1;
        @(negedge clk_sys);
        reg_wr = 1'b0; reg_rd = 1'b0;
        chk("rdwr_rdata", reg_rdata, 0);
        chk("rdwr_ack", reg_ack, 1);
        rd_chk("rdwr_readback", A_OUT, 32'h55);
        chk("rdwr_gpio_out", gpio_out[31:0], 32'h55);

        // DEB_LIMIT=0 rising edge on pin 3: EVT at k+3, irq at k+4
        do_reset();
        wr(A_DEB, 0);
        wr(A_RISE, 32'h8);
        wr(A_MASK, 32'h8);
        @(negedge clk_sys);
        gpio_in[3] = 1'b1; reg_addr = A_EVT; reg_rd = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk_sys);
            chk("evt_latency", reg_rdata, j >= 4 ? 32'h8 : 32'h0);
            chk("irq_latency", irq, j >= 4);
        end
        reg_rd = 1'b0;
        rd_chk("in_bit3", A_IN, 32'h8);
        wr(A_EVT, 32'h8);
        chk("w1c_irq_hold", irq, 1);
        @(negedge clk_sys);
        chk("w1c_irq_clear", irq, 0);
        rd_chk("w1c_evt", A_EVT, 32'h0);
        @(negedge clk_sys);
        gpio_in[3] = 1'b0; reg_addr = A_IN; reg_rd = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk_sys);
            chk("in_fall_latency", reg_rdata, j >= 3 ? 32'h0 : 32'h8);
        end
        reg_rd = 1'b0;
        rd_chk("fall_no_evt", A_EVT, 32'h0);
        chk("fall_no_irq", irq, 0);

        // DEB_LIMIT=5: 5-cycle glitch rejected, 6-cycle pulse accepted at k+7
        do_reset();
        wr(A_DEB, 5);
        wr(A_RISE, 32'h1);
        @(negedge clk_sys);
        gpio_in[0] = 1'b1;
        repeat (5) @(negedge clk_sys);
        gpio_in[0] = 1'b0;
        repeat (12) @(negedge clk_sys);
        rd_chk("glitch_in", A_IN, 32'h0);
        rd_chk("glitch_evt", A_EVT, 32'h0);
        @(negedge clk_sys);
        gpio_in[0] = 1'b1; reg_addr = A_IN; reg_rd = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk_sys);
            if (j == 5) gpio_in[0] = 1'b0;
            chk("deb_accept", reg_rdata, j >= 8 ? 32'h1 : 32'h0);
        end
        reg_rd = 1'b0;
        rd_chk("deb_evt", A_EVT, 32'h1);

        // Pulses
        do_reset();
        wr(A_PLEN, 4);
        pulse_seq("pulse_len4", 1'b0, 4);
        pulse_seq("pulse_retrig", 1'b1, 6);
        wr(A_PLEN, 0);
        pulse_seq("pulse_len0", 1'b0, 0);
        rd_chk("pulse_reads0", A_PULSE, 32'h0);
        wr(A_PLEN, 10);
        wr(A_PULSE, 32'h2);
        repeat (2) @(negedge clk_sys);
        chk("midpulse_high", gpio_out[1], 1);
        rstn_sys = 1'b0;
        @(negedge clk_sys);
        chk("midpulse_reset", gpio_out, 0);
        rstn_sys = 1'b1;
        rd_chk("reset_plen", A_PLEN, 32'h0);
        chk("reset_pulse_abort", gpio_out, 0);

        // Set beats coincident W1C; FALL_EN ignores rising edges
        do_reset();
        wr(A_RISE, 32'h4);
        @(negedge clk_sys);
        gpio_in[2] = 1'b1;
        repeat (3) @(negedge clk_sys);
        reg_addr = A_EVT; reg_wdata = 32'h4; reg_wr = 1'b1;
        @(negedge clk_sys);
        reg_wr = 1'b0;
        rd_chk("set_wins", A_EVT, 32'h4);
        wr(A_RISE, 0);
        wr(A_FALL, 32'h20);
        wr(A_EVT, 32'h4);
        @(negedge clk_sys);
        gpio_in[5] = 1'b1;
        repeat (6) @(negedge clk_sys);
        rd_chk("fall_only_rise", A_EVT, 32'h0);
        gpio_in[5] = 1'b0;
        repeat (6) @(negedge clk_sys);
        rd_chk("fall_only_fall", A_EVT, 32'h20);

        // Randomized traffic against a register-level model
        do_reset();
        begin
            int lim;
            lim = $urandom_range(0, 3);
            wr(A_DEB, 32'(lim));
            {out_m, rise_m, fall_m, mask_m, evt_m, pin_m} = '0;
            for (int r = 0; r < 25; r++) begin
                for (int n = 0; n < 3; n++) begin
                    int k, w;
                    logic [31:0] d;
                    k = $urandom_range(0, 3);
                    w = $urandom_range(0, 1);
                    d = $urandom;
                    wr(8'(2 + 2 * k + (k == 3 ? 2 : 0) + w), d);
                    case (k)
                        0: out_m = merge(out_m, w, d);
                        1: rise_m = merge(rise_m, w, d);
                        2: fall_m = merge(fall_m, w, d);
                        default: mask_m = merge(mask_m, w, d);
                    endcase
                end
                if ($urandom_range(0, 1) == 1) begin
                    int w;
                    logic [31:0] d;
                    w = $urandom_range(0, 1);
                    d = $urandom;
                    wr(8'(A_EVT + w), d);
                    evt_m = evt_m & ~merge(40'h0, w, d);
                end
                old_pin = pin_m;
                pin_m = 40'({$urandom, $urandom});
                evt_m = evt_m | (~old_pin & pin_m & rise_m) | (old_pin & ~pin_m & fall_m);
                @(negedge clk_sys);
                gpio_in = pin_m;
                repeat (lim + 6) @(negedge clk_sys);
                for (int b = 0; b < 6; b++)
                    for (int w = 0; w < 2; w++)
                        rd_chk("rand_read", 8'(2 * b + w), word_of(bank_model(b), w));
                chk("rand_gpio_out", gpio_out, out_m);
                chk("rand_irq", irq, |(evt_m & mask_m));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
